// File: rtl/shift_deserializer_pkg.sv
`default_nettype none
// ============================================================================
// Module   : shift_deser_pkg
// Brief    : Shared types and frame-length helper for the shift deserializer.
// Revision : 1.0
// ============================================================================
package shift_deser_pkg;

    typedef enum logic [0:0] {
        EMPTY = 1'b0,
        FULL  = 1'b1
    } out_state_e;

    // Bits on the wire per word: data bits plus the optional trailing parity bit.
    function automatic int frame_len(input int width, input bit parity_en);
        return parity_en ? width + 1 : width;
    endfunction

endpackage
`default_nettype wire

// File: rtl/shift_deserializer_if.sv
`default_nettype none
// ============================================================================
// Module   : shift_deserializer_if
// Brief    : Serial input and parallel valid/ready output bundle.
// Revision : 1.0
// ============================================================================
interface shift_deserializer_if #(
    parameter int WIDTH = 100
);
    logic             data_i;
    logic             valid_i;
    logic             sof_i;
    logic [WIDTH-1:0] word_o;
    logic             word_valid_o;
    logic             word_ready_i;
    logic             overflow_o;
    logic             parity_err_o;

    modport master (
        output data_i, valid_i, sof_i, word_ready_i,
        input  word_o, word_valid_o, overflow_o, parity_err_o
    );

    modport slave (
        input  data_i, valid_i, sof_i, word_ready_i,
        output word_o, word_valid_o, overflow_o, parity_err_o
    );
endinterface
`default_nettype wire

// File: rtl/shift_deserializer_out_stage.sv
`default_nettype none
// ============================================================================
// Module   : deser_out_stage
// Brief    : Registered valid/ready holding stage (word + parity flag) with
//            EMPTY/FULL control and sticky overflow.
// Revision : 1.0
// ============================================================================
module deser_out_stage
    import shift_deser_pkg::*;
#(
    parameter int WIDTH = 100
) (
    input  wire logic             clk,
    input  wire logic             reset,
    input  wire logic             load,
    input  wire logic [WIDTH-1:0] load_word,
    input  wire logic             load_perr,
    input  wire logic             ready,
    output logic      [WIDTH-1:0] word,
    output logic                  word_valid,
    output logic                  overflow,
    output logic                  parity_err
);
    localparam logic [0:0] c_st_empty = 1'(EMPTY);
    localparam logic [0:0] c_st_full  = 1'(FULL);

    logic [0:0]   r_state;
    logic [WIDTH:0] r_hold;
    logic         r_overflow;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state    <= c_st_empty;
            r_hold     <= '0;
            r_overflow <= 1'b0;
        end else begin
            case (r_state)
                c_st_empty: begin
                    if (load) begin
                        r_hold  <= {load_perr, load_word};
                        r_state <= c_st_full;
                    end
                end
                c_st_full: begin
                    if (ready) begin
                        // Simultaneous consume and load keeps the stage full with no bubble.
                        if (load) r_hold  <= {load_perr, load_word};
                        else      r_state <= c_st_empty;
                    end else if (load) begin
                        r_overflow <= 1'b1;
                    end
                end
                default: r_state <= c_st_empty;
            endcase
        end
    end

    assign word       = r_hold[WIDTH-1:0];
    assign parity_err = r_hold[WIDTH];
    assign word_valid = (r_state == c_st_full);
    assign overflow   = r_overflow;

endmodule
`default_nettype wire

// File: rtl/shift_deserializer.sv
`default_nettype none
// ============================================================================
// Module   : shift_deserializer
// Brief    : Serial-to-parallel converter, MSB-first, with registered output.
//            Optional trailing even-parity bit enabled by DESER_PARITY_EN.
// Revision : 1.0
// ============================================================================
module shift_deserializer
    import shift_deser_pkg::*;
#(
    parameter int WIDTH     = 100,
    parameter int LOG2WIDTH = 7
) (
    input  wire logic             clk,
    input  wire logic             reset,
    shift_deserializer_if.slave   bus
);
`ifdef DESER_PARITY_EN
    localparam bit c_parity_en = 1'b1;
`else
    localparam bit c_parity_en = 1'b0;
`endif
    localparam int c_frame = frame_len(WIDTH, c_parity_en);
    // The parity bit can push the last count one past what LOG2WIDTH holds.
    localparam int c_cnt_w = (c_frame <= (1 << LOG2WIDTH)) ? LOG2WIDTH : LOG2WIDTH + 1;
    localparam logic [c_cnt_w-1:0] c_last = c_cnt_w'(c_frame - 1);

    logic [WIDTH-1:0]   r_shreg;
    logic [c_cnt_w-1:0] r_bit_cnt;
    logic               w_resync;
    logic               w_complete;
    logic [WIDTH-1:0]   w_shifted;
    logic [WIDTH-1:0]   w_word;
    logic               w_perr;

    assign w_resync   = bus.valid_i & bus.sof_i;
    assign w_complete = bus.valid_i & ~bus.sof_i & (r_bit_cnt == c_last);
    assign w_shifted  = {r_shreg[WIDTH-2:0], bus.data_i};

`ifdef DESER_PARITY_EN
    // On the parity bit the data bits are already all in the shift register.
    assign w_word = r_shreg;
    assign w_perr = (^r_shreg) ^ bus.data_i;
`else
    assign w_word = w_shifted;
    assign w_perr = 1'b0;
    logic w_unused;
    assign w_unused = r_shreg[WIDTH-1];
`endif

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_shreg   <= '0;
            r_bit_cnt <= '0;
        end else if (w_resync) begin
            r_shreg   <= {{(WIDTH-1){1'b0}}, bus.data_i};
            r_bit_cnt <= c_cnt_w'(1);
        end else if (bus.valid_i) begin
            r_shreg   <= w_shifted;
            r_bit_cnt <= w_complete ? '0 : r_bit_cnt + c_cnt_w'(1);
        end
    end

    deser_out_stage #(
        .WIDTH (WIDTH)
    ) u_out_stage (
        .clk        (clk),
        .reset      (reset),
        .load       (w_complete),
        .load_word  (w_word),
        .load_perr  (w_perr),
        .ready      (bus.word_ready_i),
        .word       (bus.word_o),
        .word_valid (bus.word_valid_o),
        .overflow   (bus.overflow_o),
        .parity_err (bus.parity_err_o)
    );

endmodule
`default_nettype wire

// File: tb/tb_shift_deserializer.sv
`default_nettype none
// ============================================================================
// Module   : tb_shift_deserializer
// Brief    : Self-checking bench for shift_deserializer (WIDTH=8).
// Revision : 1.0
// ============================================================================
module tb_shift_deserializer;
    localparam int W = 8;
`ifdef DESER_PARITY_EN
    localparam bit PAR   = 1'b1;
    localparam int FRAME = W + 1;
`else
    localparam bit PAR   = 1'b0;
    localparam int FRAME = W;
`endif

    logic clk = 1'b0;
    logic reset = 1'b1;
    logic data = 1'b0, valid = 1'b0, sof = 1'b0, ready = 1'b0;
    int   n_checks = 0;
    int   n_errors = 0;

    // Reference model: bits collected so far, plus the presented output.
    bit         mq[$];
    logic [7:0] m_word;
    bit         m_valid, m_ovf, m_perr;

    shift_deserializer_if #(.WIDTH(W)) bus ();

    assign bus.data_i       = data;
    assign bus.valid_i      = valid;
    assign bus.sof_i        = sof;
    assign bus.word_ready_i = ready;

    shift_deserializer #(.WIDTH(W), .LOG2WIDTH(3)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus.slave)
    );

    always #5 clk = ~clk;

    task automatic model_reset();
        mq.delete();
        m_word = '0; m_valid = 0; m_ovf = 0; m_perr = 0;
    endtask

    task automatic model_edge(input bit d, input bit v, input bit s, input bit r);
        bit done; logic [7:0] w; bit x;
        done = 0; w = '0; x = 0;
        if (v) begin
            if (s) mq.delete();
            mq.push_back(d);
            if (!s && mq.size() == FRAME) begin
                for (int i = 0; i < W; i++) w = {w[6:0], mq[i]};
                foreach (mq[i]) x ^= mq[i];
                done = 1;
                mq.delete();
            end
        end
        if (m_valid && r) m_valid = 0;
        if (done) begin
            if (m_valid) m_ovf = 1;
            else begin
                m_valid = 1; m_word = w; m_perr = PAR ? x : 1'b0;
            end
        end
    endtask

    task automatic step(input bit d, input bit v, input bit s, input bit r);
        data = d; valid = v; sof = s; ready = r;
        @(posedge clk);
        model_edge(d, v, s, r);
        #1;
    endtask

    task automatic do_reset();
        data = 0; valid = 0; sof = 0; ready = 0;
        reset = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;
        model_reset();
    endtask

    task automatic send_word(input logic [7:0] w, input bit rdy, input bit rdy_last, input bit flip_par);
        for (int i = W - 1; i >= 0; i--)
            step(w[i], 1, 0, (i == 0 && !PAR) ? rdy_last : rdy);
        if (PAR) step((^w) ^ flip_par, 1, 0, rdy_last);
    endtask

    task automatic test_reset();
        reset = 1'b1;
        @(posedge clk); #1;
        n_checks++;
        if ({bus.word_valid_o, bus.word_o, bus.overflow_o, bus.parity_err_o} !== 11'd0) begin
            n_errors++;
            $display("FAIL reset_outputs: got valid=%b word=%h ovf=%b perr=%b required all 0",
                     bus.word_valid_o, bus.word_o, bus.overflow_o, bus.parity_err_o);
        end
        do_reset();
    endtask

    task automatic test_basic();
        do_reset();
        send_word(8'hB2, 1, 1, 0);
        n_checks++;
        if (bus.word_valid_o !== 1'b1 || bus.word_o !== 8'hB2) begin
            n_errors++;
            $display("FAIL basic_word: got valid=%b word=%h required valid=1 word=b2", bus.word_valid_o, bus.word_o);
        end
        step(0, 0, 0, 1);
        n_checks++;
        if (bus.word_valid_o !== 1'b0 || bus.overflow_o !== 1'b0) begin
            n_errors++;
            $display("FAIL basic_one_cycle: got valid=%b ovf=%b required 0 0", bus.word_valid_o, bus.overflow_o);
        end
    endtask

    task automatic test_gaps();
        logic [7:0] w;
        bit early;
        w = 8'hB2; early = 0;
        do_reset();
        for (int i = W - 1; i >= 0; i--) begin
            step(w[i], 1, 0, 1);
            if (i != 0 || PAR) early |= bus.word_valid_o;
            step(0, 0, 0, 1);
            if (i != 0 || PAR) early |= bus.word_valid_o;
            else begin
                n_checks++;
                if (bus.word_valid_o !== 1'b0) begin
                    n_errors++;
                    $display("FAIL gaps_consumed: got valid=%b required 0", bus.word_valid_o);
                end
            end
        end
        if (PAR) begin
            step(^w, 1, 0, 0);
        end else begin
            do_reset();
            for (int i = W - 1; i >= 0; i--) begin
                step(w[i], 1, 0, 0);
                if (i != 0) step(0, 0, 0, 0);
                if (i != 0) early |= bus.word_valid_o;
            end
        end
        n_checks++;
        if (early !== 1'b0) begin
            n_errors++;
            $display("FAIL gaps_early_valid: got early=%b required 0", early);
        end
        n_checks++;
        if (bus.word_valid_o !== 1'b1 || bus.word_o !== 8'hB2) begin
            n_errors++;
            $display("FAIL gaps_word: got valid=%b word=%h required valid=1 word=b2", bus.word_valid_o, bus.word_o);
        end
    endtask

    task automatic test_resync();
        logic [7:0] w;
        bit seen;
        w = 8'hFF; seen = 0;
        do_reset();
        for (int i = 0; i < 5; i++) begin
            step(1'($urandom), 1, 0, 1);
            seen |= bus.word_valid_o;
        end
        step(w[7], 1, 1, 1);
        seen |= bus.word_valid_o;
        for (int i = W - 2; i >= 0; i--) begin
            step(w[i], 1, 0, 1);
            if (i != 0 || PAR) seen |= bus.word_valid_o;
        end
        if (PAR) step(^w, 1, 0, 1);
        n_checks++;
        if (seen !== 1'b0 || bus.word_valid_o !== 1'b1 || bus.word_o !== 8'hFF) begin
            n_errors++;
            $display("FAIL resync_word: got early=%b valid=%b word=%h required 0 1 ff", seen, bus.word_valid_o, bus.word_o);
        end
        // sof landing on the final bit of a frame restarts the word instead of completing it
        do_reset();
        w = 8'hC3; seen = 0;
        for (int i = 0; i < FRAME - 1; i++) step(1, 1, 0, 1);
        step(w[7], 1, 1, 1);
        seen |= bus.word_valid_o;
        for (int i = W - 2; i >= 0; i--) begin
            step(w[i], 1, 0, 1);
            if (i != 0 || PAR) seen |= bus.word_valid_o;
        end
        if (PAR) step(^w, 1, 0, 1);
        n_checks++;
        if (seen !== 1'b0 || bus.word_valid_o !== 1'b1 || bus.word_o !== 8'hC3) begin
            n_errors++;
            $display("FAIL sof_last_bit: got early=%b valid=%b word=%h required 0 1 c3", seen, bus.word_valid_o, bus.word_o);
        end
    endtask

    task automatic test_backpressure();
        do_reset();
        send_word(8'hA5, 0, 0, 0);
        n_checks++;
        if (bus.word_valid_o !== 1'b1 || bus.word_o !== 8'hA5) begin
            n_errors++;
            $display("FAIL bp_first: got valid=%b word=%h required 1 a5", bus.word_valid_o, bus.word_o);
        end
        send_word(8'h3C, 0, 0, 0);
        n_checks++;
        if (bus.word_valid_o !== 1'b1 || bus.word_o !== 8'hA5 || bus.overflow_o !== 1'b1) begin
            n_errors++;
            $display("FAIL bp_overflow: got valid=%b word=%h ovf=%b required 1 a5 1",
                     bus.word_valid_o, bus.word_o, bus.overflow_o);
        end
        step(0, 0, 0, 1);
        n_checks++;
        if (bus.word_valid_o !== 1'b0 || bus.overflow_o !== 1'b1) begin
            n_errors++;
            $display("FAIL bp_sticky: got valid=%b ovf=%b required 0 1", bus.word_valid_o, bus.overflow_o);
        end
        do_reset();
        send_word(8'hA5, 0, 0, 0);
        send_word(8'h3C, 0, 1, 0);
        n_checks++;
        if (bus.word_valid_o !== 1'b1 || bus.word_o !== 8'h3C || bus.overflow_o !== 1'b0) begin
            n_errors++;
            $display("FAIL bp_back_to_back: got valid=%b word=%h ovf=%b required 1 3c 0",
                     bus.word_valid_o, bus.word_o, bus.overflow_o);
        end
    endtask

    task automatic test_async_reset();
        logic [7:0] w;
        w = 8'h0F;
        do_reset();
        send_word(8'hA5, 0, 0, 0);
        send_word(8'hA5, 0, 0, 0);
        for (int i = 0; i < 4; i++) step(1, 1, 0, 0);
        #3;
        reset = 1'b1;
        #1;
        n_checks++;
        if ({bus.word_valid_o, bus.word_o, bus.overflow_o, bus.parity_err_o} !== 11'd0) begin
            n_errors++;
            $display("FAIL async_reset: got valid=%b word=%h ovf=%b perr=%b required all 0",
                     bus.word_valid_o, bus.word_o, bus.overflow_o, bus.parity_err_o);
        end
        @(posedge clk); #1;
        reset = 1'b0;
        model_reset();
        send_word(w, 1, 1, 0);
        n_checks++;
        if (bus.word_valid_o !== 1'b1 || bus.word_o !== 8'h0F || bus.overflow_o !== 1'b0) begin
            n_errors++;
            $display("FAIL after_reset_word: got valid=%b word=%h ovf=%b required 1 0f 0",
                     bus.word_valid_o, bus.word_o, bus.overflow_o);
        end
    endtask

    task automatic test_parity();
        do_reset();
        send_word(8'hB2, 1, 1, 0);
        n_checks++;
        if (bus.parity_err_o !== 1'b0 || bus.word_o !== 8'hB2) begin
            n_errors++;
            $display("FAIL parity_good: got perr=%b word=%h required 0 b2", bus.parity_err_o, bus.word_o);
        end
        send_word(8'hB2, 1, 1, 1);
        n_checks++;
        if (bus.parity_err_o !== PAR || bus.word_o !== 8'hB2 || bus.word_valid_o !== 1'b1) begin
            n_errors++;
            $display("FAIL parity_bad: got perr=%b word=%h valid=%b required %b b2 1",
                     bus.parity_err_o, bus.word_o, bus.word_valid_o, PAR);
        end
    endtask

    task automatic test_random();
        bit d, v, s, r;
        do_reset();
        for (int n = 0; n < 600; n++) begin
            d = 1'($urandom);
            v = ($urandom_range(0, 9) < 7);
            s = ($urandom_range(0, 29) == 0);
            r = ($urandom_range(0, 9) < 8);
            step(d, v, s, r);
            n_checks++;
            if (bus.word_valid_o !== m_valid || bus.overflow_o !== m_ovf ||
                bus.word_o !== m_word || bus.parity_err_o !== m_perr) begin
                n_errors++;
                $display("FAIL random_cycle %0d: got valid=%b word=%h ovf=%b perr=%b required %b %h %b %b",
                         n, bus.word_valid_o, bus.word_o, bus.overflow_o, bus.parity_err_o,
                         m_valid, m_word, m_ovf, m_perr);
            end
        end
    endtask

    initial begin
        model_reset();
        test_reset();
        test_basic();
        test_gaps();
        test_resync();
        test_backpressure();
        test_async_reset();
        test_parity();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire
